// File: rtl/dot_acc_pkg.sv
// Shared types and the saturating adder helper for the dot-product accumulator.
package dot_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Working width of sat_add; callers sign-extend operands up to it.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             overflow;
    } sat_sum_t;

    // Adds two sign-extended operands and clamps the result to a signed
    // 'width'-bit range (width < SAT_W), flagging when the clamp engaged.
    function automatic sat_sum_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      width);
        logic signed [SAT_W-1:0] full;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_sum_t                r;
        full       = a + b;
        max_v      = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v      = -max_v - 64'sd1;
        r.sum      = full;
        r.overflow = 1'b0;
        if (full > max_v) begin
            r.sum      = max_v;
            r.overflow = 1'b1;
        end else if (full < min_v) begin
            r.sum      = min_v;
            r.overflow = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_adder.sv
// Sign-extending accumulator adder. DOT_ACC_SATURATE_EN selects clamping
// to the ACC_W signed range; otherwise the sum wraps and overflow is 0.
module acc_adder
    import dot_acc_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 2*N + 2
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [2*N-1:0]   prod,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

`ifdef DOT_ACC_SATURATE_EN
    sat_sum_t res;
    logic     sat_unused;

    assign res        = sat_add(SAT_W'($signed(acc)), SAT_W'($signed(prod)), ACC_W);
    assign sum        = res.sum[ACC_W-1:0];
    assign overflow   = res.overflow;
    // Clamped value always fits in ACC_W, so the upper bits are redundant.
    assign sat_unused = ^res.sum[SAT_W-1:ACC_W];
`else
    assign sum      = acc + ACC_W'($signed(prod));
    assign overflow = 1'b0;
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums TERMS signed products into one result held on a valid/ready port.
// Build with DOT_ACC_SATURATE_EN for clamping adds and a sticky sat flag.
//
//   state | meaning
//   ACCUM | accepting products, building the partial sum
//   HOLD  | result presented on acc_out, waiting for acc_ready
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int N     = 4,
    parameter int TERMS = 4,
    parameter int ACC_W = 2*N + $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [2*N-1:0]   prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             sat
);

    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] count;
    logic             add_ovf;
    logic             sat_run;
    logic             accept;
    logic             last_term;

    assign accept    = prod_valid & prod_ready;
    assign last_term = (count == CNT_W'(TERMS - 1));

    acc_adder #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_adder (
        .acc      (acc),
        .prod     (prod),
        .sum      (acc_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM: if (accept && last_term)     state_nxt = HOLD;
                HOLD:  if (acc_valid && acc_ready)  state_nxt = ACCUM;
                default:                            state_nxt = ACCUM;
            endcase
        end
    end

    // prod_ready decodes registered state only, so acc_ready never reaches it.
    always_comb begin
        prod_ready = 1'b0;
        if (state == ACCUM) begin
            prod_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            sat       <= 1'b0;
            sat_run   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            count     <= '0;
            acc_valid <= 1'b0;
            sat       <= 1'b0;
            sat_run   <= 1'b0;
        end else if (accept) begin
            if (last_term) begin
                acc_out   <= acc_sum;
                acc_valid <= 1'b1;
                sat       <= sat_run | add_ovf;
                acc       <= '0;
                count     <= '0;
                sat_run   <= 1'b0;
            end else begin
                acc     <= acc_sum;
                count   <= count + CNT_W'(1);
                sat_run <= sat_run | add_ovf;
            end
        end else if (acc_valid && acc_ready) begin
            acc_valid <= 1'b0;
            sat       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench: two accumulators (10-bit and 8-bit) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_dot_product_accumulator;

    localparam int N     = 4;
    localparam int TERMS = 4;
`ifdef DOT_ACC_SATURATE_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              clear      = 1'b0;
    logic              prod_valid = 1'b0;
    logic              acc_ready  = 1'b1;
    logic [2*N-1:0]    prod       = '0;
    logic              prod_ready_a, prod_ready_b;
    logic              acc_valid_a, acc_valid_b;
    logic              sat_a, sat_b;
    logic signed [9:0] acc_out_a;
    logic signed [7:0] acc_out_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // model state
    int     terms[$];
    bit     m_hold = 1'b0;
    longint m_out_a = 0, m_out_b = 0;
    bit     m_sat_a = 1'b0, m_sat_b = 1'b0;

    always #5 clk = ~clk;

    dot_product_accumulator #(.N(N), .TERMS(TERMS)) u_dut_a (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_a), .acc_out(acc_out_a), .acc_valid(acc_valid_a),
        .acc_ready(acc_ready), .sat(sat_a)
    );

    dot_product_accumulator #(.N(N), .TERMS(TERMS), .ACC_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_b), .acc_out(acc_out_b), .acc_valid(acc_valid_b),
        .acc_ready(acc_ready), .sat(sat_b)
    );

    // Result of summing a list of products into a w-bit signed accumulator.
    function automatic void model_result(input int q[$], input int w, input bit satmode,
                                         output longint v, output bit ov);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        v  = 0;
        ov = 1'b0;
        foreach (q[i]) begin
            v += q[i];
            if (satmode && v > hi) begin v = hi; ov = 1'b1; end
            if (satmode && v < lo) begin v = lo; ov = 1'b1; end
        end
        if (!satmode) begin
            v = v & ((longint'(1) <<< w) - 1);
            if (v > hi) v -= (longint'(1) <<< w);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            terms.delete();
            m_hold  = 1'b0;
            m_out_a = 0;
            m_out_b = 0;
            m_sat_a = 1'b0;
            m_sat_b = 1'b0;
        end else if (clear) begin
            terms.delete();
            m_hold  = 1'b0;
            m_sat_a = 1'b0;
            m_sat_b = 1'b0;
        end else if (!m_hold && prod_valid) begin
            terms.push_back(int'($signed(prod)));
            if (terms.size() == TERMS) begin
                model_result(terms, 10, SAT_MODE, m_out_a, m_sat_a);
                model_result(terms, 8, SAT_MODE, m_out_b, m_sat_b);
                m_hold = 1'b1;
                terms.delete();
            end
        end else if (m_hold && acc_ready) begin
            m_hold  = 1'b0;
            m_sat_a = 1'b0;
            m_sat_b = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("valid_a", longint'(acc_valid_a), longint'(m_hold));
        check("valid_b", longint'(acc_valid_b), longint'(m_hold));
        check("ready_a", longint'(prod_ready_a), longint'(!m_hold));
        check("ready_b", longint'(prod_ready_b), longint'(!m_hold));
        check("sat_a", longint'(sat_a), longint'(m_hold && m_sat_a));
        check("sat_b", longint'(sat_b), longint'(m_hold && m_sat_b));
        if (m_hold) begin
            check("out_a", longint'(acc_out_a), m_out_a);
            check("out_b", longint'(acc_out_b), m_out_b);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (started) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p);
        bit rdy;
        bit done = 1'b0;
        prod       = 8'(p);
        prod_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = prod_ready_a;
            step();
            done = rdy;
        end
        prod_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic expect_result(input string name, input longint ea, input longint eb,
                                 input bit esat_b);
        check({name, "_valid"}, longint'(acc_valid_a), 1);
        check({name, "_out_a"}, longint'(acc_out_a), ea);
        check({name, "_out_b"}, longint'(acc_out_b), eb);
        check({name, "_sat_a"}, longint'(sat_a), 0);
        check({name, "_sat_b"}, longint'(sat_b), longint'(esat_b));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out"}, longint'(acc_out_a), 0);
        check({name, "_valid"}, longint'(acc_valid_a), 0);
        check({name, "_sat"}, longint'(sat_b), 0);
        check({name, "_ready"}, longint'(prod_ready_a), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        check_reset_state("reset");
        rst     = 1'b0;
        started = 1'b1;

        for (int i = 0; i < 4; i++) send(49);
        expect_result("sum49", 196, SAT_MODE ? 127 : -60, SAT_MODE);
        step();
        check("valid_one_cycle", longint'(acc_valid_a), 0);

        send(64); send(-56); send(-8); send(0);
        expect_result("mixed", 0, 0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) send(-64);
        expect_result("neg64", -256, SAT_MODE ? -128 : 0, SAT_MODE);
        step();

        send(1); send(2); send(3);
        acc_ready = 1'b0;
        send(4);
        expect_result("bp", 10, 10, 1'b0);
        prod_valid = 1'b1;
        prod       = 8'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_out", longint'(acc_out_a), 10);
            check("bp_hold_ready", longint'(prod_ready_a), 0);
        end
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        step();
        check("bp_released", longint'(acc_valid_a), 0);
        check("bp_ready_back", longint'(prod_ready_a), 1);
        for (int i = 0; i < 4; i++) send(1);
        expect_result("after_bp", 4, 4, 1'b0);
        step();

        send(20); send(30);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) send(1);
        expect_result("after_clear", 4, 4, 1'b0);
        step();

        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1);
        expect_result("pre_hold_clear", 4, 4, 1'b0);
        clear     = 1'b1;
        acc_ready = 1'b1;
        step();
        clear = 1'b0;
        check("hold_clear_valid", longint'(acc_valid_a), 0);
        check("hold_clear_ready", longint'(prod_ready_a), 1);

        send(7);
        prod       = 8'd100;
        prod_valid = 1'b1;
        clear      = 1'b1;
        step();
        clear      = 1'b0;
        prod_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(1);
        expect_result("clear_discard", 4, 4, 1'b0);
        step();

        for (int i = 0; i < 4; i++) send(64);
        expect_result("sum64", 256, SAT_MODE ? 127 : 0, SAT_MODE);
        step();

        send(5); send(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_mid");
        send(1); send(2); send(3); send(4);
        expect_result("after_rst_mid", 10, 10, 1'b0);
        acc_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        acc_ready = 1'b1;
        check_reset_state("rst_hold");
        for (int i = 0; i < 4; i++) send(3);
        expect_result("after_rst_hold", 12, 12, 1'b0);
        step();

        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            prod_valid = ($urandom_range(0, 3) != 0);
            prod       = 8'($urandom);
            acc_ready  = ($urandom_range(0, 2) != 0);
            step();
        end
        rst        = 1'b0;
        clear      = 1'b0;
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
Downstream consumer of the sequential signed multiplier. Accepts a stream of signed 2N-bit products over a valid/ready handshake and sums TERMS consecutive products into one dot-product result. Presents each result on a valid/ready output port. Forms the accumulate half of a multiply-accumulate datapath.

Parameters:
N, 4, multiplier operand width; product width is 2*N
TERMS, 4, number of products summed per result (>=1)
ACC_W, 2*N+$clog2(TERMS), signed accumulator/result width (>=2*N)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous abort: discard partial sum and any held result
prod  input  2*N  signed product from multiplier
prod_valid  input  1  prod is valid this cycle
prod_ready  output  1  block can accept prod this cycle
acc_out  output  ACC_W  signed dot-product result
acc_valid  output  1  acc_out holds a complete result
acc_ready  input  1  downstream accepts acc_out this cycle
sat  output  1  result saturated (see Optional Feature); valid with acc_valid

Behaviour:
- Reset: one clock; reset is synchronous and active-high (ports clk, rst). rst wins over every other input.
- Reset values: acc_out=0, acc_valid=0, sat=0, prod_ready=1, internal acc=0, count=0, state=ACCUM.
- FSM, 2 states:
  - ACCUM: prod_ready=1.
    - Accept = prod_valid & prod_ready.
    - On accept: acc <= acc + sign_extend(prod); count <= count+1.
    - On the accept with count==TERMS-1: acc_out <= acc + sign_extend(prod); acc_valid <= 1; acc <= 0; count <= 0; -> HOLD.
  - HOLD: prod_ready=0; acc_out and sat stable.
    - On acc_valid & acc_ready: acc_valid <= 0, sat <= 0; -> ACCUM.
- prod_ready is a registered-state decode (no combinational path from acc_ready). First product of the next result can therefore be accepted one cycle after the output handshake.
- Latency: acc_valid rises on the cycle after the TERMS-th accept.
- Throughput: TERMS accepts + 1 handshake cycle per result, minimum.
- TERMS==1: every accept goes straight to HOLD.
- Arithmetic: two's complement. Product is sign-extended to ACC_W before the add. Without the feature, the sum wraps modulo 2^ACC_W (default ACC_W cannot overflow).
- clear (when rst=0): acc<=0, count<=0, acc_valid<=0, sat<=0, -> ACCUM.
  - A product presented with clear is handshaken but discarded.
  - clear in HOLD drops the result even if acc_ready=1.
- prod_valid low between products: acc and count hold; no timeout.
- Reset or clear mid-result: partial sum is lost and no result is emitted.

Optional Feature:
- Macro: DOT_ACC_SATURATE_EN.
- Defined: every add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Later terms add onto the clamped value. sat is sticky across the current result and is presented with acc_out.
- Undefined: adds wrap modulo 2^ACC_W and sat is tied to 0.

Decomposition:
- Package dot_acc_pkg holds:
  - state enum typedef {ACCUM, HOLD};
  - function sat_add(a, b, width) returning {sum, overflow}.
- Natural sub-module: acc_adder (sign-extend, add, optional saturate), combinational, ACC_W parameterised.
- FSM and counter stay in the top module.

Test Plan:
- N=4, TERMS=4, defaults: products 49,49,49,49 back-to-back, acc_ready=1 -> acc_out=196 one cycle after 4th accept, acc_valid high 1 cycle, sat=0.
- Mixed signs: 64,-56,-8,0 -> acc_out=0. Then -64,-64,-64,-64 -> acc_out=-256. Check sign extension.
- Backpressure: complete result 10 (1,2,3,4), hold acc_ready=0 for 5 cycles -> acc_out stable=10, prod_ready=0 throughout, extra prod_valid ignored; acc_ready=1 -> next result starts from 0.
- clear after 2 accepts (20,30), then 1,1,1,1 -> acc_out=4. clear in HOLD with acc_ready=1 -> no handshake, acc_valid=0 next cycle.
- ACC_W=8, products 64 x4: with DOT_ACC_SATURATE_EN -> acc_out=127, sat=1. Without it -> acc_out=0 (wrap), sat=0.
- rst asserted mid-result and in HOLD -> all outputs at reset values next cycle. Next 4 products sum with no residue.
